// File: rtl/bp_be_iter_sched.sv
// Purpose: round-robin scheduler sharing one iterative div/rem/sqrt unit between int (0) and fp (1) requesters.
// Latency: zero-cycle issue (ready/start combinational in IDLE); result held from the cycle after done until consumed.
// Backpressure: no grant while unit not ready, flushing, busy or holding a result; result held until wb_yumi_i.
module bp_be_iter_sched #(
    parameter int tag_width_p = 5,
    parameter int lat_width_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [1:0]               req_v_i,
    input  logic [2*tag_width_p-1:0] req_tag_i,
    output logic [1:0]               req_ready_o,
    input  logic                     flush_i,
    input  logic                     unit_ready_i,
    output logic                     unit_v_o,
    output logic                     unit_sel_o,
    input  logic                     unit_done_i,
    output logic                     wb_v_o,
    output logic                     wb_sel_o,
    output logic [tag_width_p-1:0]   wb_tag_o,
    input  logic                     wb_yumi_i,
    output logic                     busy_o,
    output logic [lat_width_p-1:0]   lat_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_r, state_n;
    logic                   rr_ptr_r;
    logic                   poison_r;
    logic                   sel_r;
    logic [tag_width_p-1:0] tag_r;
    logic [lat_width_p-1:0] lat_cnt_r;
    logic [lat_width_p-1:0] lat_r;
    logic                   busy_r;
    logic                   rst_q_r;
    logic                   out_en;
    logic                   accept;
    logic                   gnt_idx;

    // Outputs are forced quiet in the reset cycle and the one right after it.
    assign out_en = ~reset_i & ~rst_q_r;

    assign busy_o = out_en & busy_r;
    assign lat_o  = out_en ? lat_r : '0;

    // Remembers that the previous cycle was a reset cycle.
    always_ff @(posedge clk_i) begin
        rst_q_r <= reset_i;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state, grant and output decode.
    always_comb begin
        state_n     = state_r;
        req_ready_o = 2'b00;
        unit_v_o    = 1'b0;
        unit_sel_o  = 1'b0;
        wb_v_o      = 1'b0;
        wb_sel_o    = 1'b0;
        wb_tag_o    = '0;
        accept      = 1'b0;
        gnt_idx     = 1'b0;
        if (out_en) begin
            case (state_r)
                IDLE: begin
                    if (unit_ready_i && !flush_i && (req_v_i != 2'b00)) begin
                        // Contention resolves to the pointer; otherwise the lone valid wins.
                        gnt_idx              = (&req_v_i) ? rr_ptr_r : req_v_i[1];
                        req_ready_o[gnt_idx] = 1'b1;
                        accept               = 1'b1;
                        unit_v_o             = 1'b1;
                        unit_sel_o           = gnt_idx;
                        state_n              = BUSY;
                    end
                end
                BUSY: begin
                    // The unit cannot abort; a flushed op is drained and its result dropped.
                    if (unit_done_i) begin
                        state_n = (poison_r || flush_i) ? IDLE : DONE;
                    end
                end
                DONE: begin
                    wb_v_o   = ~flush_i;
                    wb_sel_o = sel_r;
                    wb_tag_o = tag_r;
                    if (flush_i || wb_yumi_i) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Operation bookkeeping: captured op, round-robin pointer, poison and latency counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_r  <= 1'b0;
            poison_r  <= 1'b0;
            sel_r     <= 1'b0;
            tag_r     <= '0;
            lat_cnt_r <= '0;
            lat_r     <= '0;
            busy_r    <= 1'b0;
        end else begin
            busy_r <= (state_r != IDLE);
            if (accept) begin
                sel_r     <= gnt_idx;
                tag_r     <= gnt_idx ? req_tag_i[2*tag_width_p-1:tag_width_p]
                                     : req_tag_i[tag_width_p-1:0];
                rr_ptr_r  <= ~gnt_idx;
                lat_cnt_r <= {{(lat_width_p-1){1'b0}}, 1'b1};
                poison_r  <= 1'b0;
            end else if (state_r == BUSY) begin
                if (lat_cnt_r != {lat_width_p{1'b1}}) begin
                    lat_cnt_r <= lat_cnt_r + 1'b1;
                end
                if (unit_done_i) begin
                    lat_r <= lat_cnt_r;
                end else if (flush_i) begin
                    poison_r <= 1'b1;
                end
            end
        end
    end

    // Writeback may only consume a valid result; a yumi coinciding with a flush is
    // tolerated because the flush already discards the held result that cycle.
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        wb_yumi_i |-> (wb_v_o || flush_i));

endmodule

// File: tb/tb_bp_be_iter_sched.sv
module tb_bp_be_iter_sched;

    localparam int TW     = 5;
    localparam int LW     = 4;
    localparam int MAXLAT = (1 << LW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req_v = 2'b00;
    logic [2*TW-1:0] req_tag = '0;
    logic            flush = 1'b0;
    logic            unit_ready = 1'b0;
    logic            done = 1'b0;
    logic            yumi = 1'b0;

    logic [1:0]      req_ready;
    logic            unit_v;
    logic            unit_sel;
    logic            wb_v;
    logic            wb_sel;
    logic [TW-1:0]   wb_tag;
    logic            busy;
    logic [LW-1:0]   lat;

    int checks = 0;
    int failures = 0;

    // Reference model: transaction-level view of the scheduler.
    bit          m_mask_q = 1'b0;
    bit          m_run = 1'b0;
    bit          m_hold = 1'b0;
    bit          m_poison = 1'b0;
    bit          m_rr = 1'b0;
    bit          m_sel = 1'b0;
    bit          m_busy = 1'b0;
    logic [TW-1:0] m_tag = '0;
    int          m_lat = 0;
    int          m_start = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    bp_be_iter_sched #(.tag_width_p(TW), .lat_width_p(LW)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_v_i      (req_v),
        .req_tag_i    (req_tag),
        .req_ready_o  (req_ready),
        .flush_i      (flush),
        .unit_ready_i (unit_ready),
        .unit_v_o     (unit_v),
        .unit_sel_o   (unit_sel),
        .unit_done_i  (done),
        .wb_v_o       (wb_v),
        .wb_sel_o     (wb_sel),
        .wb_tag_o     (wb_tag),
        .wb_yumi_i    (yumi),
        .busy_o       (busy),
        .lat_o        (lat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Check every output against the model mid-cycle, then advance the model across the edge.
    task automatic tick();
        bit            mask;
        bit            gv;
        bit            g;
        bit [1:0]      e_rdy;
        bit            e_wbv;
        bit            e_wbsel;
        logic [TW-1:0] e_wbtag;
        int            span;
        #4;
        mask  = reset || m_mask_q;
        gv    = 1'b0;
        g     = 1'b0;
        e_rdy = 2'b00;
        if (!mask && !m_run && !m_hold && unit_ready && !flush && req_v != 2'b00) begin
            gv    = 1'b1;
            g     = (req_v == 2'b11) ? m_rr : (req_v == 2'b10);
            e_rdy = g ? 2'b10 : 2'b01;
        end
        e_wbv   = !mask && m_hold && !flush;
        e_wbsel = !mask && m_hold && m_sel;
        e_wbtag = (!mask && m_hold) ? m_tag : '0;
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("unit_v",    32'(unit_v),    32'(gv));
        chk("unit_sel",  32'(unit_sel),  32'(g));
        chk("wb_v",      32'(wb_v),      32'(e_wbv));
        chk("wb_sel",    32'(wb_sel),    32'(e_wbsel));
        chk("wb_tag",    32'(wb_tag),    32'(e_wbtag));
        chk("busy",      32'(busy),      mask ? 32'd0 : 32'(m_busy));
        chk("lat",       32'(lat),       mask ? 32'd0 : 32'(m_lat));
        if (reset) begin
            m_mask_q = 1'b1;
            m_run    = 1'b0;
            m_hold   = 1'b0;
            m_poison = 1'b0;
            m_rr     = 1'b0;
            m_sel    = 1'b0;
            m_busy   = 1'b0;
            m_tag    = '0;
            m_lat    = 0;
        end else begin
            m_mask_q = 1'b0;
            m_busy   = m_run || m_hold;
            if (gv) begin
                m_run    = 1'b1;
                m_start  = cyc;
                m_sel    = g;
                m_tag    = g ? req_tag[2*TW-1:TW] : req_tag[TW-1:0];
                m_rr     = !g;
                m_poison = 1'b0;
            end else if (m_run) begin
                if (done) begin
                    span   = cyc - m_start;
                    m_lat  = (span > MAXLAT) ? MAXLAT : span;
                    m_run  = 1'b0;
                    m_hold = !(m_poison || flush);
                end else if (flush) begin
                    m_poison = 1'b1;
                end
            end else if (m_hold && (flush || yumi)) begin
                m_hold = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_v      = 2'b00;
        flush      = 1'b0;
        unit_ready = 1'b0;
        done       = 1'b0;
        yumi       = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Single int request, done ten cycles after the start.
        do_reset();
        unit_ready = 1'b1;
        req_v      = 2'b01;
        req_tag    = {5'd0, 5'd7};
        tick();
        req_v = 2'b00;
        repeat (9) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("lat_single", 32'(lat), 32'd10);
        yumi = 1'b1;
        #1;
        chk("wb_v_single", 32'(wb_v), 32'd1);
        chk("wb_tag_single", 32'(wb_tag), 32'd7);
        chk("wb_sel_single", 32'(wb_sel), 32'd0);
        tick();
        yumi = 1'b0;
        tick();
        chk("busy_after_yumi", 32'(busy), 32'd0);

        // Continuous contention alternates grants starting with requester 0.
        do_reset();
        unit_ready = 1'b1;
        req_v      = 2'b11;
        req_tag    = {5'd20, 5'd3};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", 32'(unit_sel), 32'(k % 2));
            tick();
            tick();
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            yumi = 1'b1;
            #1;
            chk("rr_wb_tag", 32'(wb_tag), (k % 2) ? 32'd20 : 32'd3);
            tick();
            yumi = 1'b0;
        end
        req_v = 2'b00;
        tick();

        // Flush while busy poisons the op; the next request is accepted right after.
        req_v   = 2'b01;
        req_tag = {5'd0, 5'd9};
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        #1;
        chk("accept_after_flush", 32'(req_ready), 32'd1);
        tick();
        req_v = 2'b00;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        #1;
        chk("wb_v_unpoisoned", 32'(wb_v), 32'd1);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;

        // Flush coinciding with done drops the result but still records latency.
        req_v   = 2'b01;
        req_tag = {5'd0, 5'd11};
        tick();
        req_v = 2'b00;
        tick();
        tick();
        flush = 1'b1;
        done  = 1'b1;
        tick();
        flush = 1'b0;
        done  = 1'b0;
        chk("lat_flush_done", 32'(lat), 32'd3);
        #1;
        chk("wb_v_flush_done", 32'(wb_v), 32'd0);
        tick();

        // Flush in DONE together with yumi: no valid, idle the next cycle.
        req_v   = 2'b10;
        req_tag = {5'd13, 5'd0};
        tick();
        req_v = 2'b00;
        tick();
        done = 1'b1;
        tick();
        done  = 1'b0;
        flush = 1'b1;
        yumi  = 1'b1;
        #1;
        chk("wb_v_flush_yumi", 32'(wb_v), 32'd0);
        tick();
        flush = 1'b0;
        yumi  = 1'b0;
        req_v = 2'b01;
        #1;
        chk("accept_after_done_flush", 32'(req_ready), 32'd1);
        tick();
        req_v = 2'b00;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        yumi = 1'b1;
        tick();
        yumi = 1'b0;

        // Unit backpressure, then a long op that saturates the latency counter.
        unit_ready = 1'b0;
        req_v      = 2'b10;
        req_tag    = {5'd30, 5'd0};
        repeat (5) tick();
        unit_ready = 1'b1;
        #1;
        chk("bp_release", 32'(req_ready), 32'd2);
        tick();
        req_v = 2'b00;
        repeat (19) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("lat_sat", 32'(lat), 32'(MAXLAT));
        yumi = 1'b1;
        tick();
        yumi = 1'b0;

        // Randomized traffic including occasional mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            req_v      = 2'($urandom);
            req_tag    = 10'($urandom);
            flush      = ($urandom_range(0, 15) == 0);
            unit_ready = ($urandom_range(0, 3) != 0);
            done       = ($urandom_range(0, 5) == 0);
            yumi       = !reset && m_hold && ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_be_iter_sched.md
Name: bp_be_iter_sched

Overview:
Scheduler that shares one iterative long-latency unit (divide/remainder/sqrt) between two requesters: requester 0 is integer div/rem and requester 1 is FP div/sqrt.
It arbitrates between them round-robin and issues the winner to the unit. It then tracks the in-flight operation until the unit finishes, and holds the result-valid until writeback accepts it.
It sits between the reservation output of the calculator and the shared iterative unit. Flushes poison the in-flight operation, so its result is dropped rather than written back.

Parameters:
tag_width_p, 5, width of the destination tag carried with each operation (rd address)
lat_width_p, 8, width of the saturating latency counter

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
req_v_i  input  2  per-requester request valid
req_tag_i  input  2*tag_width_p  per-requester destination tag
req_ready_o  output  2  per-requester ready; a request is accepted when v&ready in the same cycle
flush_i  input  1  pipeline flush
unit_ready_i  input  1  shared unit can accept a start
unit_v_o  output  1  start pulse to the shared unit
unit_sel_o  output  1  operation class for the start (0 int, 1 fp)
unit_done_i  input  1  single-cycle completion pulse from the shared unit
wb_v_o  output  1  result valid toward writeback
wb_sel_o  output  1  requester class of the held result
wb_tag_o  output  tag_width_p  tag of the held result
wb_yumi_i  input  1  writeback consumes the result (legal only when wb_v_o=1)
busy_o  output  1  state != IDLE
lat_o  output  lat_width_p  cycles from start to done of the last completed operation

Behaviour:
- States: IDLE, BUSY, DONE. Internal registers: rr_ptr, poison, sel_r, tag_r, lat counter.
- Reset:
  - state=IDLE, rr_ptr=0, poison=0, sel_r=0, tag_r=0, lat counter=0, lat_o=0.
  - All outputs are 0 during the reset cycle and the cycle after.
- IDLE, grant rule:
  - If unit_ready_i=1 and flush_i=0, grant one requester.
  - Both requesters valid: grant index rr_ptr.
  - One requester valid: grant that one.
  - req_ready_o is one-hot or zero. It never asserts for a non-granted requester and never asserts when flush_i=1 or unit_ready_i=0.
- IDLE, accept (req_v_i[g] & req_ready_o[g]):
  - Same cycle: unit_v_o=1 and unit_sel_o=g, both combinational.
  - Next cycle: sel_r=g, tag_r=req_tag_i[g], rr_ptr=~g, lat counter=1, poison=0, state=BUSY.
  - Zero-cycle issue latency.
- BUSY:
  - lat counter increments each cycle and saturates at all-ones.
  - unit_done_i=1 sets lat_o=counter.
  - On done: if poison=1 or flush_i=1, go to IDLE (result dropped); otherwise go to DONE.
  - flush_i=1 without done: poison=1 and the state stays BUSY. The unit cannot abort.
  - req_ready_o=0 throughout.
- DONE:
  - wb_v_o = ~flush_i; wb_sel_o=sel_r; wb_tag_o=tag_r. These values stay stable until consumed.
  - wb_yumi_i=1 returns the state to IDLE.
  - flush_i=1 returns the state to IDLE with no writeback; flush wins over a simultaneous yumi.
  - No new request is accepted in DONE. The earliest next accept is the cycle after the state returns to IDLE.
- unit_done_i outside BUSY is ignored.
- wb_yumi_i while wb_v_o=0 is a protocol error and must be covered by an assertion.
- Reset mid-operation returns to IDLE immediately; any pending result is discarded.
- busy_o is registered from state. It is 1 in BUSY and DONE.

Test Plan:
- Single int request: req_v_i=01, tag=5'd7, unit_ready_i=1 at cycle 0.
  - Cycle 0: req_ready_o=01, unit_v_o=1, unit_sel_o=0.
  - Done pulse at cycle 10: lat_o=10; cycle 11: wb_v_o=1, wb_tag_o=7, wb_sel_o=0.
  - yumi at cycle 11: busy_o=0 at cycle 13.
- Contention: req_v_i=11 held continuously, done 3 cycles after each start, yumi immediately.
  - Grants alternate 0,1,0,1 (rr_ptr starts at 0).
  - The tag of each wb matches the requester granted.
- Flush in BUSY: flush_i pulses 2 cycles after start; done arrives 4 cycles later.
  - wb_v_o stays 0; state returns to IDLE.
  - A new request is accepted the following cycle with poison=0.
- Flush and done together in BUSY: no wb_v_o assertion; lat_o still updates.
- Flush in DONE concurrent with wb_yumi_i: wb_v_o=0 that cycle; IDLE next cycle.
- Backpressure and saturation:
  - unit_ready_i=0 with req_v_i=10: req_ready_o=00 and unit_v_o=0 until ready rises.
  - With lat_width_p=4 and done after 20 cycles: lat_o=4'hF.
